// File: rtl/ar_rx_arbiter.sv
// Merges ARINC-429 words from N_CH receivers into one output stream.
// One hold register per channel, round-robin grant onto a single output register.
module ar_rx_arbiter #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CH_W      = 2,
  parameter bit          DROP_PERR = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH*8-1:0]  ch_adr,
  input  logic [N_CH*23-1:0] ch_dat,
  input  logic [N_CH-1:0]    ch_ce_wr,
  input  logic [N_CH-1:0]    ch_res,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [CH_W-1:0]    out_ch,
  output logic [7:0]         out_adr,
  output logic [22:0]        out_dat,
  output logic               out_perr,
  output logic [N_CH-1:0]    ovr,
  output logic [N_CH-1:0]    perr,
  input  logic               flag_clr
);

  logic [N_CH-1:0] pend_q, pend_d;
  logic [7:0]      adr_q  [N_CH];
  logic [7:0]      adr_d  [N_CH];
  logic [22:0]     dat_q  [N_CH];
  logic [22:0]     dat_d  [N_CH];
  logic [N_CH-1:0] wperr_q, wperr_d;

  logic            out_vld_q, out_vld_d;
  logic [CH_W-1:0] out_ch_q, out_ch_d;
  logic [7:0]      out_adr_q, out_adr_d;
  logic [22:0]     out_dat_q, out_dat_d;
  logic            out_perr_q, out_perr_d;

  logic [CH_W-1:0] rr_q, rr_d;
  logic [N_CH-1:0] ovr_q, ovr_d, perr_q, perr_d;

  logic            gnt;
  logic            found;
  logic [CH_W-1:0] gnt_idx;
  logic [CH_W-1:0] scan_idx;

  // First pending channel at or after rr, wrapping modulo N_CH.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      scan_idx = CH_W'((32'(rr_q) + i) % N_CH);
      if (!found && pend_q[scan_idx]) begin
        found   = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    gnt = found && (!out_vld_q || out_rdy);
  end

  always_comb begin
    logic gnt_k;
    logic cap;
    logic [N_CH-1:0] ovr_set;
    logic [N_CH-1:0] perr_set;
    pend_d   = pend_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    wperr_d  = wperr_q;
    ovr_set  = '0;
    perr_set = '0;
    gnt_k    = 1'b0;
    cap      = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      gnt_k = gnt && (gnt_idx == CH_W'(k));
      cap   = ch_ce_wr[k] && (!DROP_PERR || ch_res[k]);
      // A recapture on the granted channel keeps pend set and is not an overrun.
      pend_d[k]   = cap || (pend_q[k] && !gnt_k);
      ovr_set[k]  = cap && pend_q[k] && !gnt_k;
      perr_set[k] = ch_ce_wr[k] && !ch_res[k];
      if (cap) begin
        adr_d[k]   = ch_adr[8*k +: 8];
        dat_d[k]   = ch_dat[23*k +: 23];
        wperr_d[k] = !ch_res[k];
      end
    end
    // Set events win over a simultaneous clear.
    ovr_d  = (flag_clr ? '0 : ovr_q) | ovr_set;
    perr_d = (flag_clr ? '0 : perr_q) | perr_set;
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    out_ch_d   = out_ch_q;
    out_adr_d  = out_adr_q;
    out_dat_d  = out_dat_q;
    out_perr_d = out_perr_q;
    rr_d       = rr_q;
    if (gnt) begin
      out_vld_d  = 1'b1;
      out_ch_d   = gnt_idx;
      out_adr_d  = adr_q[gnt_idx];
      out_dat_d  = dat_q[gnt_idx];
      out_perr_d = wperr_q[gnt_idx];
      rr_d       = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_vld_q && out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      wperr_q    <= '0;
      out_vld_q  <= 1'b0;
      out_ch_q   <= '0;
      out_adr_q  <= '0;
      out_dat_q  <= '0;
      out_perr_q <= 1'b0;
      rr_q       <= '0;
      ovr_q      <= '0;
      perr_q     <= '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        adr_q[k] <= '0;
        dat_q[k] <= '0;
      end
    end else begin
      pend_q     <= pend_d;
      wperr_q    <= wperr_d;
      out_vld_q  <= out_vld_d;
      out_ch_q   <= out_ch_d;
      out_adr_q  <= out_adr_d;
      out_dat_q  <= out_dat_d;
      out_perr_q <= out_perr_d;
      rr_q       <= rr_d;
      ovr_q      <= ovr_d;
      perr_q     <= perr_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_ch   = out_ch_q;
  assign out_adr  = out_adr_q;
  assign out_dat  = out_dat_q;
  assign out_perr = out_perr_q;
  assign ovr      = ovr_q;
  assign perr     = perr_q;

endmodule

// File: tb/tb_ar_rx_arbiter.sv
// Directed + randomized bench for ar_rx_arbiter against a word-level reference model.
module tb_ar_rx_arbiter;

  localparam int N    = 4;
  localparam int CHW  = 2;
  localparam bit DROP = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N*8-1:0]  ch_adr;
  logic [N*23-1:0] ch_dat;
  logic [N-1:0]  ch_ce_wr;
  logic [N-1:0]  ch_res;
  logic          out_vld;
  logic          out_rdy;
  logic [CHW-1:0] out_ch;
  logic [7:0]    out_adr;
  logic [22:0]   out_dat;
  logic          out_perr;
  logic [N-1:0]  ovr;
  logic [N-1:0]  perr;
  logic          flag_clr;

  ar_rx_arbiter #(.N_CH(N), .CH_W(CHW), .DROP_PERR(DROP)) dut (
    .clk(clk), .rst_n(rst_n), .ch_adr(ch_adr), .ch_dat(ch_dat), .ch_ce_wr(ch_ce_wr),
    .ch_res(ch_res), .out_vld(out_vld), .out_rdy(out_rdy), .out_ch(out_ch),
    .out_adr(out_adr), .out_dat(out_dat), .out_perr(out_perr), .ovr(ovr), .perr(perr),
    .flag_clr(flag_clr)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one held word per channel, one output word, rotating pointer.
  bit          m_pend [N];
  logic [7:0]  m_adr  [N];
  logic [22:0] m_dat  [N];
  bit          m_bad  [N];
  int          m_rr;
  bit          m_vld;
  int          m_ch;
  logic [7:0]  m_oadr;
  logic [22:0] m_odat;
  bit          m_operr;
  logic [N-1:0] m_ovr, m_perr;

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_pend[k] = 0; m_adr[k] = '0; m_dat[k] = '0; m_bad[k] = 0;
    end
    m_rr = 0; m_vld = 0; m_ch = 0; m_oadr = '0; m_odat = '0; m_operr = 0;
    m_ovr = '0; m_perr = '0;
  endfunction

  function automatic void model_edge();
    int g;
    g = -1;
    if (!m_vld || out_rdy) begin
      for (int i = 0; i < N; i++) begin
        if (g < 0 && m_pend[(m_rr + i) % N]) g = (m_rr + i) % N;
      end
      if (g >= 0) begin
        m_vld = 1; m_ch = g; m_oadr = m_adr[g]; m_odat = m_dat[g]; m_operr = m_bad[g];
        m_pend[g] = 0;
        m_rr = (g + 1) % N;
      end else if (m_vld) begin
        m_vld = 0;
      end
    end
    if (flag_clr) begin
      m_ovr = '0; m_perr = '0;
    end
    for (int k = 0; k < N; k++) begin
      if (ch_ce_wr[k]) begin
        if (!ch_res[k]) m_perr[k] = 1'b1;
        if (!DROP || ch_res[k]) begin
          if (m_pend[k]) m_ovr[k] = 1'b1;
          m_pend[k] = 1;
          m_adr[k]  = ch_adr[8*k +: 8];
          m_dat[k]  = ch_dat[23*k +: 23];
          m_bad[k]  = !ch_res[k];
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("out_vld", 32'(out_vld), 32'(m_vld));
    check("out_ch", 32'(out_ch), 32'(m_ch));
    check("out_adr", 32'(out_adr), 32'(m_oadr));
    check("out_dat", 32'(out_dat), 32'(m_odat));
    check("out_perr", 32'(out_perr), 32'(m_operr));
    check("ovr", 32'(ovr), 32'(m_ovr));
    check("perr", 32'(perr), 32'(m_perr));
  endtask

  task automatic strobe(input int k, input logic [7:0] a, input logic [22:0] d, input bit r);
    ch_adr[8*k +: 8]   = a;
    ch_dat[23*k +: 23] = d;
    ch_res[k]          = r;
    ch_ce_wr[k]        = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    ch_ce_wr = '0;
    flag_clr = 1'b0;
    check_all();
  endtask

  // Asynchronous reset pulse placed mid-cycle.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check_all();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ch_adr = '0; ch_dat = '0; ch_ce_wr = '0; ch_res = '1;
    out_rdy = 1'b1; flag_clr = 1'b0;
    model_reset();
    #25;
    check_all();
    rst_n = 1'b1;

    // 1: single word, two-edge latency
    strobe(2, 8'hA5, 23'h12345, 1'b1);
    step();
    check("t1_vld_e1", 32'(out_vld), 32'd0);
    step();
    check("t1_vld_e2", 32'(out_vld), 32'd1);
    check("t1_ch", 32'(out_ch), 32'd2);
    check("t1_adr", 32'(out_adr), 32'hA5);
    check("t1_dat", 32'(out_dat), 32'h12345);
    check("t1_perr", 32'(out_perr), 32'd0);
    step();
    check("t1_vld_e3", 32'(out_vld), 32'd0);

    // 2: simultaneous burst, round-robin order and wrap
    do_reset();
    for (int k = 0; k < N; k++) strobe(k, 8'(8'h10 + k), 23'(k), 1'b1);
    step();
    for (int k = 0; k < N; k++) begin
      step();
      check("t2_ch", 32'(out_ch), 32'(k));
      check("t2_adr", 32'(out_adr), 32'(8'h10 + k));
    end
    step();
    for (int k = 0; k < N; k++) strobe(k, 8'(8'h18 + k), 23'(k), 1'b1);
    step();
    step();
    check("t2_wrap_ch", 32'(out_ch), 32'd0);
    for (int i = 0; i < N; i++) step();

    // 3: stall with overrun on ch1
    do_reset();
    out_rdy = 1'b0;
    strobe(0, 8'h40, 23'h40, 1'b1);
    step();
    step();
    strobe(1, 8'h20, 23'h20, 1'b1);
    step();
    step();
    strobe(1, 8'h21, 23'h21, 1'b1);
    step();
    check("t3_ovr1", 32'(ovr[1]), 32'd1);
    check("t3_frozen", 32'(out_adr), 32'h40);
    step();
    check("t3_frozen2", 32'(out_adr), 32'h40);
    out_rdy = 1'b1;
    step();
    check("t3_ch", 32'(out_ch), 32'd1);
    check("t3_adr", 32'(out_adr), 32'h21);
    step();

    // 4: parity error on ch3, then flag clear
    strobe(3, 8'h33, 23'h33, 1'b0);
    step();
    step();
    check("t4_perr3", 32'(perr[3]), 32'd1);
    check("t4_vld", 32'(out_vld), 32'(!DROP));
    flag_clr = 1'b1;
    step();
    check("t4_clr_perr", 32'(perr), 32'd0);
    check("t4_clr_ovr", 32'(ovr), 32'd0);

    // 5: grant and recapture on ch1 in the same cycle
    step();
    strobe(1, 8'h30, 23'h30, 1'b1);
    step();
    strobe(1, 8'h31, 23'h31, 1'b1);
    step();
    check("t5_adr0", 32'(out_adr), 32'h30);
    check("t5_ovr1", 32'(ovr[1]), 32'd0);
    step();
    check("t5_adr1", 32'(out_adr), 32'h31);
    step();

    // 6: asynchronous reset with words pending and output full
    out_rdy = 1'b0;
    strobe(0, 8'h50, 23'h50, 1'b1);
    step();
    step();
    strobe(1, 8'h61, 23'h61, 1'b1);
    strobe(3, 8'h63, 23'h63, 1'b1);
    step();
    check("t6_vld_pre", 32'(out_vld), 32'd1);
    do_reset();
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_no_word", 32'(out_vld), 32'd0);
    end

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 2) == 0)
          strobe(k, 8'($urandom), 23'($urandom), $urandom_range(0, 7) != 0);
      end
      out_rdy  = $urandom_range(0, 3) != 0;
      flag_clr = $urandom_range(0, 15) == 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ar_rx_arbiter.md
Name: ar_rx_arbiter

Overview:
Merges received ARINC-429 words from N_CH independent receivers into one output stream. Each receiver presents an 8-bit label, 23-bit data, a one-cycle write strobe and a parity flag. The block holds one word per channel and grants the shared output port round-robin. It sits between the receiver bank and the downstream word FIFO or memory writer.

Parameters:
N_CH, 4, number of receiver channels (2..8)
CH_W, 2, channel-id width, which must equal ceil(log2(N_CH))
DROP_PERR, 0, 1 = words with a parity error are discarded at capture

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  asynchronous active-low reset
ch_adr  in  N_CH*8  per-channel label; channel k occupies bits [8k+7:8k]
ch_dat  in  N_CH*23  per-channel data; channel k occupies bits [23k+22:23k]
ch_ce_wr  in  N_CH  per-channel one-cycle word-ready strobe
ch_res  in  N_CH  per-channel parity flag (1 = parity correct), valid with ch_ce_wr
out_vld  out  1  output word valid
out_rdy  in  1  downstream accepts the word
out_ch  out  CH_W  source channel of the output word
out_adr  out  8  output label
out_dat  out  23  output data
out_perr  out  1  output word had a parity error
ovr  out  N_CH  sticky per-channel overrun flags
perr  out  N_CH  sticky per-channel parity-error flags
flag_clr  in  1  one-cycle pulse that clears ovr and perr

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all hold registers empty (pend=0)
  - out_vld=0; out_ch, out_adr, out_dat, out_perr = 0
  - ovr=0, perr=0
  - round-robin pointer rr=0
- Capture:
  - On a clk edge with ch_ce_wr[k]=1, hold register k loads adr, dat and !res, and sets pend[k].
  - With DROP_PERR=1 and ch_res[k]=0: no load, pend[k] is unchanged, perr[k] is still set.
  - With DROP_PERR=0: the word is stored and perr[k] is set.
- Overrun:
  - Condition: ch_ce_wr[k]=1 while pend[k]=1 and channel k is not granted in the same cycle.
  - The new word overwrites the held word and ovr[k] is set.
  - If channel k is granted in that same cycle, the old word goes to the output, the new word is captured, pend[k] stays 1, and there is no overrun.
- Output register state: EMPTY (out_vld=0) or FULL (out_vld=1).
  - A load is allowed when EMPTY, or when FULL and out_rdy=1 (back-to-back, no bubble).
  - On load: grant the first k with pend[k]=1, scanning rr, rr+1, … modulo N_CH.
  - Copy k, adr, dat and perr to the out_* ports, clear pend[k] (unless recaptured the same cycle), and set rr=(k+1) mod N_CH.
  - FULL and out_rdy=1 with no pend: go to EMPTY, out_vld=0.
  - FULL and out_rdy=0: all out_* ports are held stable and no grant occurs.
  - rr changes only on a grant.
- Latency:
  - Strobe at edge t sets pend at t.
  - Output loads at edge t+1 if the port is free, so out_vld=1 in the cycle after the edge following the strobe.
  - Minimum strobe-to-out_vld latency is 2 clk edges.
- Throughput: one word per clock when out_rdy is held at 1.
- Sticky flags:
  - flag_clr=1 clears ovr and perr.
  - A set event in the same cycle as flag_clr wins (the flag ends at 1).
- Input timing: ch_* inputs are synchronous to clk. Receivers guarantee a one-cycle ce_wr, and at most one strobe per channel per cycle.
- rst_n asserted mid-transfer drops any held and output word; there is no partial output.

Test Plan:
1. Reset, then strobe on ch2 with adr=8'hA5, dat=23'h12345, res=1, out_rdy=1.
   - out_vld=1 exactly 2 edges later with out_ch=2, adr=A5, dat=12345, perr=0.
   - out_vld=0 on the next cycle.
2. ch0..ch3 strobe together with adr=10,11,12,13 and out_rdy=1.
   - Outputs appear on 4 consecutive cycles in order ch0,1,2,3.
   - A second simultaneous burst then starts at ch0 (rr wrapped to 0).
3. Hold out_rdy=0; strobe ch1 with adr=20, then ch1 with adr=21 two cycles later.
   - ovr[1]=1, and the pending word is adr=21.
   - out_* stay frozen on the earlier word until out_rdy=1.
4. Strobe ch3 with res=0.
   - DROP_PERR=0: output carries out_perr=1 and perr[3]=1.
   - DROP_PERR=1: no output word, perr[3]=1.
   - After a flag_clr pulse, perr=0.
5. ch1 is pending and granted in the same cycle as a new ch1 strobe (adr=30 then adr=31).
   - Both words are output in order, and ovr[1]=0.
6. Drop rst_n asynchronously mid-cycle while out_vld=1 with pend=4'b1010.
   - out_vld=0 immediately, and no word is output after reset releases.
